cmp_event_filter: RTL
=====================

# cmp_event_filter

Debounces the lt/eq/gt relation stream from the N-bit magnitude comparator and reports only stable relation changes as events. Sits directly downstream of the comparator. Accepts one relation sample per valid/ready beat, holds a candidate relation until it persists for DEBOUNCE consecutive samples, then commits it and emits a from/to event through a one-entry output buffer.

## Interface
- DEBOUNCE, 4: consecutive identical accepted samples required to commit a new relation; legal range 1..255.
- CNT_W, 16: width of the committed-event counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  relation sample present.
- in_ready  out  1  block can accept a sample this cycle.
- lt  in  1  comparator "a < b".
- eq  in  1  comparator "a == b".
- gt  in  1  comparator "a > b".
- state_o  out  2  committed relation (REL_* encoding).
- ev_valid  out  1  event buffer holds an event.
- ev_ready  in  1  consumer takes the event.
- ev_from  out  2  relation before the commit.
- ev_to  out  2  relation after the commit.
- ev_count  out  CNT_W  number of commits since reset, wraps modulo 2^CNT_W.
- err  out  1  one-cycle pulse: the previous accepted sample had an illegal encoding.

## Operation
- Encoding: REL_UNK=2'b00, REL_LT=2'b01, REL_EQ=2'b10, REL_GT=2'b11. A legal sample has exactly one of lt/eq/gt set.
- Reset values: state_o=REL_UNK, candidate=REL_UNK, run counter=0, ev_valid=0, ev_from=ev_to=0, ev_count=0, err=0. in_ready=0 while rst_n is low.
- Accept: a sample is accepted when in_valid && in_ready. in_ready = !ev_valid || ev_ready.
- Per accepted legal sample r, the block is in one of three cases:
  - r == state_o: candidate := state_o, run := 0. No event.
  - r == candidate != state_o: run := run+1. When run+1 == DEBOUNCE, commit.
  - Otherwise: candidate := r, run := 1. When DEBOUNCE == 1, commit immediately.
- Commit: state_o := r. The event buffer loads ev_from=old state_o and ev_to=r, and sets ev_valid. ev_count increments. candidate := r, run := 0.
- The first commit after reset always has ev_from=REL_UNK.
- Illegal sample (zero or more than one flag set): the sample is consumed and has no relation effect. candidate := state_o, run := 0. err pulses the next cycle.
- Event buffer: ev_valid clears on ev_valid && ev_ready unless a commit occurs in the same cycle. A commit and a drain in the same cycle reload the buffer, and ev_valid stays 1.
- Run counter width: $clog2(DEBOUNCE+1). The counter never exceeds DEBOUNCE-1.

## Timing
- Latency from the accepted sample that commits to state_o, ev_valid and ev_count updated: 1 cycle, registered.
- err is registered and asserts 1 cycle after acceptance of the illegal sample.
- ev_ready to in_ready is the only combinational path. No other input-to-output combinational paths exist.
- Backpressure: while ev_valid=1 and ev_ready=0, no samples are accepted. The run state is frozen.
- Reset mid-operation: all state clears asynchronously. A pending event is dropped. The first accepted sample after deassertion is treated as a fresh candidate.
- ev_count wraps from 2^CNT_W-1 to 0 with no flag.

## Structure
- Package cmp_pkg holds:
  - typedef rel_e (2-bit enum REL_UNK/LT/EQ/GT);
  - function onehot_to_rel(lt,eq,gt) returning the relation and a legal bit;
  - the event struct {rel_e from, to}.
- Sub-module cmp_run_counter: saturating persistence counter with clear, load-one and increment inputs and a hit output (run+1 == DEBOUNCE).
- The top level contains the candidate/state registers, the commit decision and the one-entry event buffer.

## Test plan
- Reset, then 4 accepted eq samples with ev_ready=1: event from=00, to=10 one cycle after the 4th sample; state_o=10; ev_count=1.
- From state EQ, send gt,gt,gt,lt,gt,gt,gt,gt: no event until the 8th sample, then from=10, to=11; ev_count=2.
- From state GT, send 4 lt samples with ev_ready=0: event held. in_ready=0, and a 5th lt sample is not accepted until ev_ready=1. No duplicate event occurs.
- Send sample lt=1, gt=1 during a run of 2 eq samples: err pulses one cycle later, the run is cleared, and 4 further eq samples are needed to commit.
- DEBOUNCE=1, CNT_W=2: alternate lt/gt for 5 samples. An event occurs on each sample, and ev_count goes 1,2,3,0,1.
- Assert rst_n low after 3 of 4 gt samples with an event pending: all outputs return to reset values, and no event appears after deassertion.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types for the comparator relation event filter: relation encoding,
// one-hot flag decoder and the from/to event record.
package cmp_pkg;

    typedef enum logic [1:0] {
        REL_UNK = 2'b00,
        REL_LT  = 2'b01,
        REL_EQ  = 2'b10,
        REL_GT  = 2'b11
    } rel_e;

    typedef struct packed {
        rel_e from;
        rel_e to;
    } cmp_event_t;

    typedef struct packed {
        logic legal;
        rel_e rel;
    } rel_dec_t;

    // A sample is legal only when exactly one of the three flags is set.
    function automatic rel_dec_t onehot_to_rel(input logic lt, input logic eq, input logic gt);
        rel_dec_t dec;
        dec.legal = (lt ^ eq ^ gt) && !(lt && eq && gt);
        if (lt)      dec.rel = REL_LT;
        else if (eq) dec.rel = REL_EQ;
        else if (gt) dec.rel = REL_GT;
        else         dec.rel = REL_UNK;
        return dec;
    endfunction

endpackage

// File: rtl/cmp_run_counter.sv
// Persistence counter for the debounce candidate. Counts consecutive matching
// samples, never beyond DEBOUNCE-1, and flags when one more match commits.
module cmp_run_counter #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic load_one_i,
    input  logic inc_i,
    output logic hit_o
);

    localparam int RUN_W = $clog2(DEBOUNCE + 1);

    logic [RUN_W-1:0] run_q, run_d;

    always_comb begin
        run_d = run_q;
        if (clear_i) begin
            run_d = '0;
        end else if (load_one_i) begin
            run_d = RUN_W'(1);
        end else if (inc_i && (int'(run_q) < DEBOUNCE - 1)) begin
            run_d = run_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= '0;
        end else begin
            run_q <= run_d;
        end
    end

    assign hit_o = (int'(run_q) + 1 == DEBOUNCE);

endmodule

// File: rtl/cmp_event_filter.sv
// Debounces the comparator lt/eq/gt stream and emits a from/to event through a
// one-entry buffer each time a new relation has persisted for DEBOUNCE samples.
module cmp_event_filter
    import cmp_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             lt,
    input  logic             eq,
    input  logic             gt,
    output logic [1:0]       state_o,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [1:0]       ev_from,
    output logic [1:0]       ev_to,
    output logic [CNT_W-1:0] ev_count,
    output logic             err
);

    rel_e             state_q, state_d;
    rel_e             cand_q, cand_d;
    cmp_event_t       ev_q, ev_d;
    logic             ev_valid_q, ev_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    rel_dec_t smp;
    logic     accept;
    logic     commit;
    logic     run_clear, run_load, run_inc, run_hit;

    // The drain handshake is the only input allowed to reach in_ready combinationally.
    assign in_ready = rst_n && (!ev_valid_q || ev_ready);
    assign accept   = in_valid && in_ready;
    assign smp      = onehot_to_rel(lt, eq, gt);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        cand_d     = cand_q;
        ev_d       = ev_q;
        ev_valid_d = ev_valid_q;
        cnt_d      = cnt_q;
        err_d      = 1'b0;
        commit     = 1'b0;
        run_clear  = 1'b0;
        run_load   = 1'b0;
        run_inc    = 1'b0;

        if (accept) begin
            if (!smp.legal) begin
                err_d     = 1'b1;
                cand_d    = state_q;
                run_clear = 1'b1;
            end else if (smp.rel == state_q) begin
                cand_d    = state_q;
                run_clear = 1'b1;
            end else if (smp.rel == cand_q) begin
                run_inc = 1'b1;
                commit  = run_hit;
            end else begin
                cand_d   = smp.rel;
                run_load = 1'b1;
                commit   = (DEBOUNCE == 1);
            end
        end

        // A commit reloads the buffer even when it is being drained this cycle.
        if (commit) begin
            state_d    = smp.rel;
            cand_d     = smp.rel;
            run_clear  = 1'b1;
            ev_d       = '{from: state_q, to: smp.rel};
            ev_valid_d = 1'b1;
            cnt_d      = cnt_q + 1'b1;
        end else if (ev_valid_q && ev_ready) begin
            ev_valid_d = 1'b0;
        end
    end

    cmp_run_counter #(
        .DEBOUNCE(DEBOUNCE)
    ) u_run (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (run_clear),
        .load_one_i(run_load),
        .inc_i     (run_inc),
        .hit_o     (run_hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= REL_UNK;
            cand_q     <= REL_UNK;
            ev_q       <= '0;
            ev_valid_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cand_q     <= cand_d;
            ev_q       <= ev_d;
            ev_valid_q <= ev_valid_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign state_o  = state_q;
    assign ev_valid = ev_valid_q;
    assign ev_from  = ev_q.from;
    assign ev_to    = ev_q.to;
    assign ev_count = cnt_q;
    assign err      = err_q;

endmodule
